number_entry: RTL and testbench

NUMBER_ENTRY -- requirements
Module: number_entry

---
 rtl/keypad_pkg.sv | 7 +
 rtl/key_edge_detect.sv | 15 +
 rtl/number_entry.sv | 94 +++++++++
 tb/tb_number_entry.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes and entry-mode states shared by the number-entry block
package keypad_pkg;
   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_ENTER = 4'hC;
   typedef enum logic {ENTRY, HOLD} entry_state_t;
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: one event pulse per keystrobe rising edge, plus the code sampled with it
module key_edge_detect (
   input  logic       clk,
   input  logic       rst,
   input  logic       keystrobe,
   input  logic [3:0] keycode,
   output logic       key_event,
   output logic [3:0] key
);
   logic prev;
   // prev starts high so a key held through reset release stays silent
   always_ff @(posedge clk) prev <= rst ? 1'b1 : keystrobe;
   assign key_event = keystrobe & ~prev & ~rst;
   assign key = keycode;
endmodule

// File: rtl/number_entry.sv
// number_entry: keypad-driven BCD entry buffer with backspace, clear and enter-latch
module number_entry
   import keypad_pkg::*;
#(
   parameter int NDIG   = 4,
   parameter int MAXDIG = 9
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       keystrobe,
   input  logic [3:0]                 keycode,
   output logic [4*NDIG-1:0]          digits,
   output logic [$clog2(NDIG+1)-1:0]  count,
   output logic                       full,
   output logic [4*NDIG-1:0]          value,
   output logic                       value_valid,
   output logic                       overflow
);
   localparam int W  = 4*NDIG;
   localparam int CW = $clog2(NDIG+1);
   localparam logic [3:0]    MAXK = 4'(MAXDIG);
   localparam logic [CW-1:0] CMAX = CW'(NDIG);
   entry_state_t state, state_n;
   logic          ev;
   logic [3:0]    key;
   logic          is_dig, is_clr, is_bksp, is_ent;
   logic [W-1:0]  digits_n, value_n;
   logic [CW-1:0] count_n;
   logic          vv_n, ovf_n;
   key_edge_detect u_edge (
      .clk       (clk),
      .rst       (rst),
      .keystrobe (keystrobe),
      .keycode   (keycode),
      .key_event (ev),
      .key       (key)
   );
   assign is_dig  = ev && key <= MAXK;
   assign is_clr  = ev && key == KEY_CLEAR;
   assign is_bksp = ev && key == KEY_BKSP;
   assign is_ent  = ev && key == KEY_ENTER;
   assign full    = count == CMAX;
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ENTRY;
         digits      <= '0;
         count       <= '0;
         value       <= '0;
         value_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state       <= state_n;
         digits      <= digits_n;
         count       <= count_n;
         value       <= value_n;
         value_valid <= vv_n;
         overflow    <= ovf_n;
      end
   end
   always_comb begin
      state_n = state;
      if (is_clr) state_n = ENTRY;
      else if (state == ENTRY && is_ent) state_n = HOLD;
      else if (state == HOLD && is_dig) state_n = ENTRY;
   end
   always_comb begin
      digits_n = digits;
      count_n  = count;
      value_n  = value;
      vv_n     = 1'b0;
      ovf_n    = 1'b0;
      if (is_clr) begin
         digits_n = '0;
         count_n  = '0;
      end else if (state == HOLD) begin
         if (is_dig) begin
            digits_n = W'(key);
            count_n  = CW'(key != 4'd0);
         end
      end else if (is_dig) begin
         if (full) ovf_n = 1'b1;
         else if (key != 4'd0 || count != '0) begin
            digits_n = (digits << 4) | W'(key);
            count_n  = count + CW'(1);
         end
      end else if (is_bksp && count != '0) begin
         digits_n = digits >> 4;
         count_n  = count - CW'(1);
      end else if (is_ent) begin
         value_n = count == '0 ? '0 : digits;
         vv_n    = 1'b1;
      end
   end
endmodule

// File: tb/tb_number_entry.sv
// tb_number_entry: vector table, hand sequences and random stimulus against a queue-based model
module tb_number_entry;
   logic        tb_clk = 1'b0;
   logic        rst = 1'b1;
   logic        keystrobe = 1'b0;
   logic [3:0]  keycode = 4'd0;
   logic [15:0] digits, value;
   logic [2:0]  count;
   logic        full, value_valid, overflow;
   int n_checks = 0;
   int n_fail = 0;
   int m_q[$];
   bit m_hold, m_vv, m_of, m_prev;
   logic [15:0] m_val;
   typedef struct {
      logic [3:0]  key;
      logic [15:0] d;
      int          c;
      logic [15:0] v;
      int          vv;
      int          of;
   } vec_t;
   vec_t tbl[$];
   number_entry #(.NDIG(4), .MAXDIG(9)) dut (
      .clk         (tb_clk),
      .rst         (rst),
      .keystrobe   (keystrobe),
      .keycode     (keycode),
      .digits      (digits),
      .count       (count),
      .full        (full),
      .value       (value),
      .value_valid (value_valid),
      .overflow    (overflow)
   );
   always #5 tb_clk = ~tb_clk;
   function automatic logic [15:0] m_digits();
      logic [15:0] d = 16'd0;
      foreach (m_q[i]) d = d * 16 + 16'(m_q[i]);
      return d;
   endfunction
   task automatic model_step(input bit r, input bit s, input logic [3:0] k);
      m_vv = 0;
      m_of = 0;
      if (r) begin
         m_q.delete();
         m_hold = 0;
         m_val = 16'd0;
         m_prev = 1;
         return;
      end
      if (s && !m_prev) begin
         if (k == 4'hA) begin
            m_q.delete();
            m_hold = 0;
         end else if (k <= 4'd9) begin
            if (m_hold) begin
               m_q.delete();
               if (k != 0) m_q.push_back(int'(k));
               m_hold = 0;
            end else if (m_q.size() == 4) m_of = 1;
            else if (!(k == 0 && m_q.size() == 0)) m_q.push_back(int'(k));
         end else if (k == 4'hB && !m_hold) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
         end else if (k == 4'hC && !m_hold) begin
            m_val = m_digits();
            m_vv = 1;
            m_hold = 1;
         end
      end
      m_prev = s;
   endtask
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   task automatic tick(input bit r, input bit s, input logic [3:0] k);
      @(negedge tb_clk);
      rst = r;
      keystrobe = s;
      keycode = k;
      @(posedge tb_clk);
      model_step(r, s, k);
      #1;
   endtask
   task automatic press(input vec_t t);
      int vcnt = 0;
      int ocnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, t.key);
         vcnt += int'(value_valid);
         ocnt += int'(overflow);
      end
      tick(0, 0, t.key);
      vcnt += int'(value_valid);
      ocnt += int'(overflow);
      chk($sformatf("digits after key %0h", t.key), 32'(digits), 32'(t.d));
      chk($sformatf("count after key %0h", t.key), 32'(count), 32'(t.c));
      chk($sformatf("full after key %0h", t.key), 32'(full), 32'(t.c == 4));
      chk($sformatf("value after key %0h", t.key), 32'(value), 32'(t.v));
      chk($sformatf("value_valid pulses key %0h", t.key), 32'(vcnt), 32'(t.vv));
      chk($sformatf("overflow pulses key %0h", t.key), 32'(ocnt), 32'(t.of));
   endtask
   initial begin
      bit s = 0;
      tbl = '{
         '{4'h1, 16'h0001, 1, 16'h0, 0, 0}, '{4'h2, 16'h0012, 2, 16'h0, 0, 0},
         '{4'h3, 16'h0123, 3, 16'h0, 0, 0}, '{4'hA, 16'h0000, 0, 16'h0, 0, 0},
         '{4'h0, 16'h0000, 0, 16'h0, 0, 0}, '{4'h0, 16'h0000, 0, 16'h0, 0, 0},
         '{4'h5, 16'h0005, 1, 16'h0, 0, 0}, '{4'hB, 16'h0000, 0, 16'h0, 0, 0},
         '{4'h7, 16'h0007, 1, 16'h0, 0, 0}, '{4'hA, 16'h0000, 0, 16'h0, 0, 0},
         '{4'h9, 16'h0009, 1, 16'h0, 0, 0}, '{4'h8, 16'h0098, 2, 16'h0, 0, 0},
         '{4'h7, 16'h0987, 3, 16'h0, 0, 0}, '{4'h6, 16'h9876, 4, 16'h0, 0, 0},
         '{4'h5, 16'h9876, 4, 16'h0, 0, 1}, '{4'hA, 16'h0000, 0, 16'h0, 0, 0},
         '{4'h4, 16'h0004, 1, 16'h0, 0, 0}, '{4'h2, 16'h0042, 2, 16'h0, 0, 0},
         '{4'hC, 16'h0042, 2, 16'h0042, 1, 0}, '{4'h3, 16'h0003, 1, 16'h0042, 0, 0},
         '{4'hC, 16'h0003, 1, 16'h0003, 1, 0}, '{4'hB, 16'h0003, 1, 16'h0003, 0, 0},
         '{4'hC, 16'h0003, 1, 16'h0003, 0, 0}, '{4'hD, 16'h0003, 1, 16'h0003, 0, 0},
         '{4'h0, 16'h0000, 0, 16'h0003, 0, 0}, '{4'hB, 16'h0000, 0, 16'h0003, 0, 0},
         '{4'hC, 16'h0000, 0, 16'h0000, 1, 0}, '{4'hA, 16'h0000, 0, 16'h0000, 0, 0}
      };
      tick(1, 0, 0);
      tick(1, 0, 0);
      chk("reset digits", 32'(digits), 0);
      chk("reset count", 32'(count), 0);
      chk("reset value", 32'(value), 0);
      chk("reset value_valid", 32'(value_valid), 0);
      chk("reset overflow", 32'(overflow), 0);
      chk("reset full", 32'(full), 0);
      tick(0, 0, 0);
      foreach (tbl[i]) press(tbl[i]);
      tick(0, 1, 4'h1);
      tick(0, 0, 4'h1);
      tick(0, 1, 4'h5);
      tick(0, 1, 4'h5);
      chk("held 5 digits", 32'(digits), 32'h0015);
      tick(1, 1, 4'h5);
      chk("rst digits", 32'(digits), 0);
      chk("rst count", 32'(count), 0);
      chk("rst value", 32'(value), 0);
      tick(0, 1, 4'h5);
      tick(0, 1, 4'h7);
      tick(0, 1, 4'h7);
      chk("held through reset count", 32'(count), 0);
      chk("held through reset digits", 32'(digits), 0);
      tick(0, 0, 4'h5);
      tick(0, 1, 4'h5);
      chk("repress after reset digits", 32'(digits), 32'h0005);
      chk("repress after reset count", 32'(count), 1);
      tick(0, 0, 4'h0);
      tick(1, 1, 4'h3);
      chk("rst beats event count", 32'(count), 0);
      tick(0, 1, 4'h3);
      chk("no event after rst count", 32'(count), 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) s = ~s;
         tick($urandom_range(0, 199) == 0, s, 4'($urandom_range(0, 15)));
         chk("rand digits", 32'(digits), 32'(m_digits()));
         chk("rand count", 32'(count), 32'(m_q.size()));
         chk("rand full", 32'(full), 32'(m_q.size() == 4));
         chk("rand value", 32'(value), 32'(m_val));
         chk("rand value_valid", 32'(value_valid), 32'(m_vv));
         chk("rand overflow", 32'(overflow), 32'(m_of));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
